// File: rtl/merge_sort_engine_if.sv
// Bus between the register file / host and the merge sorter: start/done control,
// the parallel read bus and the single register file write port.
interface merge_sort_engine_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
);
    // Handshake: start is a request sampled only while the engine is idle; busy is high
    // for the whole sort, done pulses for one cycle after it, and WE qualifies
    // WriteAddress/WriteBus as a write that the register file commits at the next edge.
    logic                    start;
    logic [DEPTH*DATA_W-1:0] rd_bus;
    logic                    WE;
    logic [ADDR_W-1:0]       WriteAddress;
    logic [DATA_W-1:0]       WriteBus;
    logic                    busy;
    logic                    done;

    modport master (output start, rd_bus, input WE, WriteAddress, WriteBus, busy, done);
    modport slave  (input start, rd_bus, output WE, WriteAddress, WriteBus, busy, done);
endinterface

// File: rtl/merge_sort_engine.sv
// Bottom-up merge sorter: even passes merge rd_bus into scratch, odd passes merge scratch
// back into the register file, then a final copy. Define MSORT_DESCEND_EN for descending order.
module merge_sort_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    merge_sort_engine_if.slave   bus,
    output logic [1:0]           stateDbg
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MERGE = 2'd1;
    localparam logic [1:0] S_COPY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PASS = ADDR_W'(ADDR_W - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pass;
    logic [ADDR_W-1:0] idx;
    logic [PW-1:0]     ia;
    logic [PW-1:0]     ib;
    logic [DATA_W-1:0] scratch [DEPTH];
    logic [DATA_W-1:0] rdArr [DEPTH];
    logic [ADDR_W-1:0] lastAddr;
    logic [DATA_W-1:0] lastData;

    logic [PW-1:0]     runW;
    logic [PW-1:0]     pairBase;
    logic [PW-1:0]     aEnd;
    logic [PW-1:0]     bEnd;
    logic [PW-1:0]     curA;
    logic [PW-1:0]     curB;
    logic              aDone;
    logic              bDone;
    logic              takeA;
    logic [DATA_W-1:0] srcA;
    logic [DATA_W-1:0] srcB;
    logic [DATA_W-1:0] selData;
    logic              liveWe;
    logic [DATA_W-1:0] liveData;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            rdArr[j] = bus.rd_bus[DATA_W*j +: DATA_W];
        end
    end

    // Pointers reload combinationally on the first output of every pair, so the
    // registered ia/ib only carry progress within a pair.
    always_comb begin
        runW     = PW'(1) << pass;
        pairBase = {1'b0, idx} & ~((runW << 1) - PW'(1));
        aEnd     = pairBase + runW;
        bEnd     = aEnd + runW;
        curA     = ({1'b0, idx} == pairBase) ? pairBase : ia;
        curB     = ({1'b0, idx} == pairBase) ? aEnd : ib;
        aDone    = (curA >= aEnd);
        bDone    = (curB >= bEnd);
        if (pass[0]) begin
            srcA = scratch[curA[ADDR_W-1:0]];
            srcB = scratch[curB[ADDR_W-1:0]];
        end else begin
            srcA = rdArr[curA[ADDR_W-1:0]];
            srcB = rdArr[curB[ADDR_W-1:0]];
        end
`ifdef MSORT_DESCEND_EN
        takeA = bDone || (!aDone && (srcA >= srcB));
`else
        takeA = bDone || (!aDone && (srcA <= srcB));
`endif
        selData  = takeA ? srcA : srcB;
        liveWe   = ((state == S_MERGE) && pass[0]) || (state == S_COPY);
        liveData = (state == S_COPY) ? scratch[idx] : selData;
    end

    assign bus.WE           = liveWe;
    assign bus.WriteAddress = liveWe ? idx : lastAddr;
    assign bus.WriteBus     = liveWe ? liveData : lastData;
    assign bus.busy         = (state == S_MERGE) || (state == S_COPY);
    assign bus.done         = (state == S_DONE);
    assign stateDbg         = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            pass     <= '0;
            idx      <= '0;
            ia       <= '0;
            ib       <= '0;
            lastAddr <= '0;
            lastData <= '0;
        end else begin
            if (liveWe) begin
                lastAddr <= idx;
                lastData <= liveData;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_MERGE;
                        pass  <= '0;
                        idx   <= '0;
                    end
                end
                S_MERGE: begin
                    ia  <= takeA ? curA + PW'(1) : curA;
                    ib  <= takeA ? curB : curB + PW'(1);
                    idx <= idx + ADDR_W'(1);
                    if (idx == LAST_IDX) begin
                        // An even last pass leaves the result in scratch and needs the copy.
                        if (pass == LAST_PASS) begin
                            state <= LAST_PASS[0] ? S_DONE : S_COPY;
                        end else begin
                            pass <= pass + ADDR_W'(1);
                        end
                    end
                end
                S_COPY: begin
                    idx <= idx + ADDR_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if ((state == S_MERGE) && !pass[0]) begin
            scratch[idx] <= selData;
        end
    end
endmodule

// File: tb/tb_merge_sort_engine.sv
// Bench for merge_sort_engine: register file model, array-level merge model checked every
// cycle, final-order check against an insertion sort, and literal pins.
module tb_merge_sort_engine;
    logic       clock;
    logic       reset;
    logic [1:0] stateDbg;

    merge_sort_engine_if #(.DATA_W(8), .DEPTH(32), .ADDR_W(5)) sif ();

    merge_sort_engine #(.DATA_W(8), .DEPTH(32), .ADDR_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (sif),
        .stateDbg (stateDbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // register file with host load port and the engine write port
    logic [7:0] rf [32];
    logic       hostWe;
    logic [4:0] hostAddr;
    logic [7:0] hostData;

    always @(posedge clock) begin
        if (hostWe) rf[hostAddr] <= hostData;
        else if (sif.WE) rf[sif.WriteAddress] <= sif.WriteBus;
    end

    always_comb begin
        for (int j = 0; j < 32; j++) sif.rd_bus[8*j +: 8] = rf[j];
    end

    // model state
    logic [7:0] src [32];
    logic [7:0] mdlIn [32];
    logic [7:0] mdl [5][32];
    int         checks;
    int         errors;
    int         cyc;
    bit         trackOn;
    bit         repeatMode;
    int         sortsDone;
    int         weCount;
    logic [4:0] expAddr;
    logic [7:0] expBus;

    function automatic bit ordered(input logic [7:0] a, input logic [7:0] b);
`ifdef MSORT_DESCEND_EN
        return a >= b;
`else
        return a <= b;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual %0d required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic build_model();
        logic [7:0] cur [32];
        for (int k = 0; k < 32; k++) cur[k] = mdlIn[k];
        for (int p = 0; p < 5; p++) begin
            int w;
            w = 1 << p;
            for (int b = 0; b < 32; b += 2 * w) begin
                int a;
                int bb;
                a  = b;
                bb = b + w;
                for (int i = b; i < b + 2 * w; i++) begin
                    bit ta;
                    if (bb >= b + 2 * w) ta = 1'b1;
                    else if (a >= b + w) ta = 1'b0;
                    else ta = ordered(cur[a], cur[bb]);
                    if (ta) begin mdl[p][i] = cur[a]; a++; end
                    else begin mdl[p][i] = cur[bb]; bb++; end
                end
            end
            for (int k = 0; k < 32; k++) cur[k] = mdl[p][k];
        end
    endtask

    // expected outputs for cycle c of a sort (c > 193 or c == 0 means idle)
    task automatic check_cycle(input int c);
        bit expWe;
        int p;
        int i;
        expWe = 1'b0;
        if (c >= 1 && c <= 160) begin
            p = (c - 1) / 32;
            i = (c - 1) % 32;
            if (p % 2 == 1) begin
                expWe   = 1'b1;
                expAddr = 5'(i);
                expBus  = mdl[p][i];
            end
        end else if (c >= 161 && c <= 192) begin
            i       = c - 161;
            expWe   = 1'b1;
            expAddr = 5'(i);
            expBus  = mdl[4][i];
        end
        if (expWe) weCount++;
        if (c == 193) sortsDone++;
        chk("busy", int'(sif.busy), int'(c >= 1 && c <= 192));
        chk("done", int'(sif.done), int'(c == 193));
        chk("we", int'(sif.WE), int'(expWe));
        chk("waddr", int'(sif.WriteAddress), int'(expAddr));
        chk("wbus", int'(sif.WriteBus), int'(expBus));
    endtask

    // compare process
    always @(negedge clock) begin
        if (trackOn) begin
            cyc++;
            if (repeatMode && cyc == 194) begin
                check_cycle(194);
                for (int k = 0; k < 32; k++) mdlIn[k] = mdl[4][k];
                build_model();
                cyc = 0;
            end else begin
                check_cycle(cyc);
            end
        end
    end

    // driver tasks
    task automatic load_list();
        for (int k = 0; k < 32; k++) begin
            @(posedge clock); #1;
            hostWe   = 1'b1;
            hostAddr = 5'(k);
            hostData = src[k];
        end
        @(posedge clock); #1;
        hostWe = 1'b0;
        for (int k = 0; k < 32; k++) mdlIn[k] = src[k];
        build_model();
    endtask

    task automatic start_sort();
        @(posedge clock); #1;
        sif.start = 1'b1;
        @(posedge clock); #1;
        sif.start = 1'b0;
        cyc       = 0;
        trackOn   = 1'b1;
    endtask

    task automatic check_final();
        logic [7:0] srt [32];
        int bad;
        for (int k = 0; k < 32; k++) srt[k] = src[k];
        for (int k = 1; k < 32; k++) begin
            logic [7:0] key;
            int j;
            key = srt[k];
            j   = k - 1;
            while (j >= 0 && !ordered(srt[j], key)) begin
                srt[j+1] = srt[j];
                j--;
            end
            srt[j+1] = key;
        end
        bad = 0;
        for (int k = 0; k < 32; k++) if (rf[k] !== srt[k]) bad++;
        chk("final_order_bad_count", bad, 0);
    endtask

    task automatic run_sort();
        start_sort();
        repeat (195) @(posedge clock);
        #1 trackOn = 1'b0;
        check_final();
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 32; k++) begin
`ifdef MSORT_DESCEND_EN
            src[k] = 8'(k);
`else
            src[k] = 8'(31 - k);
`endif
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; trackOn = 1'b0; repeatMode = 1'b0;
        sortsDone = 0; weCount = 0; expAddr = '0; expBus = '0;
        hostWe = 1'b0; hostAddr = '0; hostData = '0;
        sif.start = 1'b0;
        for (int k = 0; k < 32; k++) rf[k] = 8'h00;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_we", int'(sif.WE), 0);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_done", int'(sif.done), 0);
        chk("rst_waddr", int'(sif.WriteAddress), 0);
        chk("rst_wbus", int'(sif.WriteBus), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // ramp in the reverse of the target order
        fill_ramp();
        load_list();
`ifdef MSORT_DESCEND_EN
        chk("model_pass0_e0", int'(mdl[0][0]), 1);
        chk("model_pass0_e1", int'(mdl[0][1]), 0);
`else
        chk("model_pass0_e0", int'(mdl[0][0]), 30);
        chk("model_pass0_e1", int'(mdl[0][1]), 31);
`endif
        run_sort();
`ifdef MSORT_DESCEND_EN
        chk("ramp_rf0", int'(rf[0]), 31);
        chk("ramp_rf31", int'(rf[31]), 0);
`else
        chk("ramp_rf0", int'(rf[0]), 0);
        chk("ramp_rf31", int'(rf[31]), 31);
`endif

        // all equal: unchanged, 96 write cycles
        for (int k = 0; k < 32; k++) src[k] = 8'hAA;
        load_list();
        weCount = 0;
        run_sort();
        chk("flat_we_cycles", weCount, 96);
        chk("flat_rf17", int'(rf[17]), 8'hAA);

        // extremes and duplicates: 7x00, 12x7F, 6x80, 7xFF
        for (int k = 0; k < 32; k++) begin
            case (k % 5)
                0: src[k] = 8'hFF;
                1: src[k] = 8'h00;
                2, 3: src[k] = 8'h7F;
                default: src[k] = 8'h80;
            endcase
        end
        load_list();
        run_sort();
`ifndef MSORT_DESCEND_EN
        chk("mix_rf6", int'(rf[6]), 8'h00);
        chk("mix_rf7", int'(rf[7]), 8'h7F);
        chk("mix_rf18", int'(rf[18]), 8'h7F);
        chk("mix_rf19", int'(rf[19]), 8'h80);
        chk("mix_rf25", int'(rf[25]), 8'hFF);
`endif

        // random lists, wide and narrow value ranges
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 32; k++) src[k] = 8'((t % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3));
            load_list();
            run_sort();
        end

        // start raised mid-sort and held: ignored, second sort begins at cycle 194
        fill_ramp();
        load_list();
        start_sort();
        sortsDone  = 0;
        repeatMode = 1'b1;
        wait (cyc == 50);
        sif.start = 1'b1;
        wait (sortsDone == 2);
        sif.start  = 1'b0;
        repeatMode = 1'b0;
        repeat (4) @(posedge clock);
        #1 trackOn = 1'b0;
        check_final();

        // reset during pass 1, then a full sort
        for (int k = 0; k < 32; k++) src[k] = 8'($urandom_range(0, 255));
        load_list();
        start_sort();
        wait (cyc == 40);
        trackOn = 1'b0;
        reset   = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_we", int'(sif.WE), 0);
        chk("midrst_busy", int'(sif.busy), 0);
        chk("midrst_done", int'(sif.done), 0);
        chk("midrst_waddr", int'(sif.WriteAddress), 0);
        expAddr = '0;
        expBus  = '0;
        fill_ramp();
        load_list();
        run_sort();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
